adc_spi_sequencer: RTL and testbench

- Downstream stage of the adc_ctrl AXI4-Lite register block.
- Takes a start strobe, channel mask and SCLK divider from the control registers.
- Runs one SPI conversion frame per enabled channel against an external 8-channel 12-bit ADC.
- Returns each result, tagged with its channel, for the register block to capture.

---
 rtl/adc_spi_sequencer.sv | 278 +++++++++++++++++++++++++++
 tb/tb_adc_spi_sequencer.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_sequencer.sv
// ---------------------------------------------------------------------------
// adc_spi_sequencer
//
// Scans the channels enabled in a mask, running one SPI frame per channel
// against an external 8-channel 12-bit ADC, and hands each result back,
// tagged with its channel, for the register block to capture.
//
// Frame timing, with H = clk_div+1 ACLK cycles and E0 the frame start edge:
//   E0          cs_n falls, mosi = frame bit 15
//   E0+H+2kH    sclk rises, miso sampled        (k = 0..FRAME_BITS-1)
//   E0+2H+2kH   sclk falls, mosi advances
//   E0+33H      cs_n rises, sample_valid pulses
//   E0+34H      next enabled channel's frame begins
//
// Ports:
//   ACLK          system clock
//   ARESET        asynchronous active-high reset
//   start         one-cycle scan request (accepted only when idle)
//   ch_mask       channel enables, bit i enables channel i
//   clk_div       SCLK half-period minus one, in ACLK cycles
//   busy          high from the accepted start until the scan has ended
//   sample_valid  one-cycle pulse qualifying sample_data / sample_ch
//   sample_data   conversion result (held between pulses)
//   sample_ch     channel of sample_data (held between pulses)
//   done          one-cycle pulse at scan end
//   sclk          SPI clock, CPOL=0
//   cs_n          ADC chip select, active low
//   mosi          SPI data to the ADC
//   miso          SPI data from the ADC
// ---------------------------------------------------------------------------
module adc_spi_sequencer #(
  parameter int NCH        = 8,
  parameter int DATA_W     = 12,
  parameter int DIV_W      = 8,
  parameter int FRAME_BITS = 16
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              start,
  input  logic [NCH-1:0]    ch_mask,
  input  logic [DIV_W-1:0]  clk_div,
  output logic              busy,
  output logic              sample_valid,
  output logic [DATA_W-1:0] sample_data,
  output logic [2:0]        sample_ch,
  output logic              done,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int BC_W = $clog2(FRAME_BITS);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP,
    FINISH
  } state_t;

  // Index of the lowest set bit of a channel mask.
  function automatic logic [2:0] lowest_ch(input logic [NCH-1:0] m);
    logic [2:0] idx;
    idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Command word: two zero bits, the channel address, then zero padding.
  function automatic logic [FRAME_BITS-1:0] frame_word(input logic [2:0] c);
    logic [FRAME_BITS-1:0] w;
    w = '0;
    w[FRAME_BITS-3 -: 3] = c;
    return w;
  endfunction

  state_t state, next_state;

  // Datapath state
  logic [DIV_W-1:0]      div_r,   div_d;    // divider latched at start
  logic [DIV_W-1:0]      cnt,     cnt_d;    // ACLK cycles into current half-period
  logic [NCH-1:0]        rem,     rem_d;    // channels still to convert
  logic [2:0]            ch,      ch_d;     // channel of the frame in flight
  logic [FRAME_BITS-2:0] tx,      tx_d;     // command bits not yet on mosi
  logic [DATA_W-1:0]     rx,      rx_d;     // miso shift register
  logic [BC_W-1:0]       bit_cnt, bit_cnt_d;  // sclk falls seen this frame

  // Next values of the registered outputs
  logic              sclk_d, cs_n_d, mosi_d, busy_d, done_d, sample_valid_d;
  logic [DATA_W-1:0] sample_data_d;
  logic [2:0]        sample_ch_d;

  logic                  tick;
  logic                  last_fall;
  logic                  load_frame;
  logic [NCH-1:0]        scan_src;
  logic [NCH-1:0]        rem_after;
  logic [2:0]            next_ch;
  logic [FRAME_BITS-1:0] frame;

  // One H period has elapsed in the current state.
  assign tick      = (cnt == div_r);
  // The falling sclk edge that closes the frame.
  assign last_fall = sclk && (bit_cnt == BC_W'(FRAME_BITS - 1));

  // The first frame takes its channel straight from the mask input; later
  // frames pick from the remaining channels, so disabled ones cost nothing.
  assign scan_src  = (state == IDLE) ? ch_mask : rem;
  assign next_ch   = lowest_ch(scan_src);
  assign rem_after = scan_src & (scan_src - NCH'(1));
  assign frame     = frame_word(next_ch);

  assign load_frame = ((state == IDLE) && start && (ch_mask != '0)) ||
                      ((state == GAP) && tick);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: clocked processes use non-blocking assignments so every register
  // samples the values from before the edge, independent of process order.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= next_state;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = (ch_mask != '0) ? SETUP : FINISH;
      SETUP:   if (tick) next_state = SHIFT;
      SHIFT:   if (tick && last_fall) next_state = HOLD;
      HOLD:    if (tick) next_state = (rem != '0) ? GAP : FINISH;
      GAP:     if (tick) next_state = SETUP;
      // done is raised on the first FINISH cycle for an empty mask and is
      // already high on entry after the last frame; leave once it is seen.
      FINISH:  if (done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output and datapath next-value logic
  // -------------------------------------------------------------------------
  // NOTE: every signal gets a default before the case statement, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    div_d          = div_r;
    cnt_d          = cnt + DIV_W'(1);
    rem_d          = rem;
    ch_d           = ch;
    tx_d           = tx;
    rx_d           = rx;
    bit_cnt_d      = bit_cnt;
    sclk_d         = sclk;
    cs_n_d         = cs_n;
    mosi_d         = mosi;
    busy_d         = busy;
    sample_data_d  = sample_data;
    sample_ch_d    = sample_ch;
    sample_valid_d = 1'b0;
    done_d         = 1'b0;

    // The divider restarts on every H boundary and on every state change.
    if ((state == IDLE) || tick || (next_state != state)) cnt_d = '0;

    case (state)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          div_d  = clk_div;
        end
      end

      SETUP: begin
        if (tick) begin
          sclk_d = 1'b1;
          rx_d   = {rx[DATA_W-2:0], miso};
        end
      end

      SHIFT: begin
        if (tick) begin
          if (sclk) begin
            sclk_d    = 1'b0;
            bit_cnt_d = bit_cnt + BC_W'(1);
            if (last_fall) begin
              mosi_d = 1'b0;
            end else begin
              mosi_d = tx[FRAME_BITS-2];
              tx_d   = {tx[FRAME_BITS-3:0], 1'b0};
            end
          end else begin
            sclk_d = 1'b1;
            // Only the low DATA_W bits of the frame are kept; the leading
            // bits shift out of the top and are discarded.
            rx_d   = {rx[DATA_W-2:0], miso};
          end
        end
      end

      HOLD: begin
        if (tick) begin
          cs_n_d         = 1'b1;
          sample_valid_d = 1'b1;
          sample_data_d  = rx;
          sample_ch_d    = ch;
          done_d         = (rem == '0);
        end
      end

      FINISH: begin
        if (done) busy_d = 1'b0;
        else      done_d = 1'b1;
      end

      default: ;
    endcase

    // Frame start: drop cs_n and present the command MSB in the same edge.
    if (load_frame) begin
      ch_d      = next_ch;
      rem_d     = rem_after;
      cs_n_d    = 1'b0;
      mosi_d    = frame[FRAME_BITS-1];
      tx_d      = frame[FRAME_BITS-2:0];
      rx_d      = '0;
      bit_cnt_d = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      div_r        <= '0;
      cnt          <= '0;
      rem          <= '0;
      ch           <= '0;
      tx           <= '0;
      rx           <= '0;
      bit_cnt      <= '0;
      sclk         <= 1'b0;
      cs_n         <= 1'b1;
      mosi         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sample_valid <= 1'b0;
      sample_data  <= '0;
      sample_ch    <= '0;
    end else begin
      div_r        <= div_d;
      cnt          <= cnt_d;
      rem          <= rem_d;
      ch           <= ch_d;
      tx           <= tx_d;
      rx           <= rx_d;
      bit_cnt      <= bit_cnt_d;
      sclk         <= sclk_d;
      cs_n         <= cs_n_d;
      mosi         <= mosi_d;
      busy         <= busy_d;
      done         <= done_d;
      sample_valid <= sample_valid_d;
      sample_data  <= sample_data_d;
      sample_ch    <= sample_ch_d;
    end
  end

endmodule

// File: tb/tb_adc_spi_sequencer.sv
// ---------------------------------------------------------------------------
// tb_adc_spi_sequencer
//
// Drives scans into adc_spi_sequencer while an ADC model answers on miso
// and a monitor records frames, samples and pulses with cycle timestamps.
// Expected channel order, data and timing are computed from the scan rules
// (frame period 34H, sample at E0+33H, ascending channels).
// ---------------------------------------------------------------------------
module tb_adc_spi_sequencer;

  logic        ACLK    = 1'b0;
  logic        ARESET  = 1'b1;
  logic        start   = 1'b0;
  logic [7:0]  ch_mask = '0;
  logic [7:0]  clk_div = '0;
  logic        miso    = 1'b0;
  logic        busy, sample_valid, done, sclk, cs_n, mosi;
  logic [11:0] sample_data;
  logic [2:0]  sample_ch;

  adc_spi_sequencer dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .start        (start),
    .ch_mask      (ch_mask),
    .clk_div      (clk_div),
    .busy         (busy),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .sample_ch    (sample_ch),
    .done         (done),
    .sclk         (sclk),
    .cs_n         (cs_n),
    .mosi         (mosi),
    .miso         (miso)
  );

  always #5 ACLK = ~ACLK;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge ACLK) cyc <= cyc + 1;

  typedef struct {
    int          fall;
    int          rise;
    int          rises;
    int          first_rise;
    int          last_rise;
    logic [15:0] mosi_w;
  } frame_t;

  typedef struct {
    int          t;
    logic [11:0] d;
    logic [2:0]  ch;
    logic        dn;
  } samp_t;

  logic [15:0] resp_word [8];   // ADC response per channel
  logic [15:0] resp_q [$];      // responses in expected frame order
  frame_t      frames [$];
  samp_t       samps [$];
  int          done_cycs [$];
  int          busy_fall   = -1;
  int          rises_total = 0;

  frame_t      cur;
  logic [15:0] cur_word  = '0;
  logic        prev_cs   = 1'b1;
  logic        prev_sclk = 1'b0;
  logic        prev_busy = 1'b0;
  logic        in_frame  = 1'b0;

  // ADC model and bus monitor, evaluated between active edges.
  always @(negedge ACLK) begin
    if (ARESET) begin
      in_frame  = 1'b0;
      prev_cs   = 1'b1;
      prev_sclk = 1'b0;
      prev_busy = 1'b0;
      miso      = 1'b0;
    end else begin
      if (prev_cs && !cs_n) begin
        in_frame       = 1'b1;
        cur.fall       = cyc;
        cur.rise       = -1;
        cur.rises      = 0;
        cur.first_rise = -1;
        cur.last_rise  = -1;
        cur.mosi_w     = '0;
        cur_word       = (resp_q.size() > 0) ? resp_q.pop_front() : 16'h0000;
        miso           = cur_word[15];
      end
      if (!prev_sclk && sclk) begin
        rises_total++;
        if (in_frame) begin
          if (cur.rises == 0) cur.first_rise = cyc;
          cur.last_rise = cyc;
          cur.rises++;
          cur.mosi_w = {cur.mosi_w[14:0], mosi};
        end
      end
      if (prev_sclk && !sclk) begin
        cur_word = {cur_word[14:0], 1'b0};
        miso     = cur_word[15];
      end
      if (!prev_cs && cs_n && in_frame) begin
        cur.rise = cyc;
        frames.push_back(cur);
        in_frame = 1'b0;
      end
      if (sample_valid) samps.push_back('{t: cyc, d: sample_data, ch: sample_ch, dn: done});
      if (done) done_cycs.push_back(cyc);
      if (prev_busy && !busy) busy_fall = cyc;
      prev_cs   = cs_n;
      prev_sclk = sclk;
      prev_busy = busy;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  // Pulse start for one cycle; s returns the cycle number of the edge
  // that samples it.
  task automatic pulse_start(input logic [7:0] m, input logic [7:0] d, output int s);
    @(negedge ACLK);
    ch_mask = m;
    clk_div = d;
    start   = 1'b1;
    @(negedge ACLK);
    start = 1'b0;
    s     = cyc;
  endtask

  // Run one scan and compare everything observed against the scan rules.
  task automatic scan_and_verify(input logic [7:0] m, input logic [7:0] d,
                                 input bit poke_mid, input bit poke_done);
    int          exp_ch [$];
    int          s, h, n, t_done, budget, rises0, c;
    logic [15:0] ew;

    exp_ch = {};
    for (int i = 0; i < 8; i++) if (m[i]) exp_ch.push_back(i);
    n = exp_ch.size();
    h = int'(d) + 1;
    resp_q = {};
    foreach (exp_ch[j]) resp_q.push_back(resp_word[exp_ch[j]]);
    frames    = {};
    samps     = {};
    done_cycs = {};
    busy_fall = -1;
    rises0    = rises_total;

    pulse_start(m, d, s);
    // Inputs are latched at start; later values must not matter.
    ch_mask = 8'($urandom);
    clk_div = 8'($urandom);

    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL busy_at_start: got %b expected 1", busy);
    end
    checks++;
    if (cs_n !== (n == 0)) begin
      errors++; $display("FAIL cs_n_at_start: got %b expected %b", cs_n, (n == 0));
    end

    t_done = (n == 0) ? s + 1 : s + 33 * h + 34 * h * (n - 1);
    budget = t_done - s + 20;
    for (int i = 0; i < budget && busy_fall < 0; i++) begin
      @(negedge ACLK);
      start = 1'b0;
      if (poke_mid && i == 20) begin
        start = 1'b1; ch_mask = 8'hFF;
      end
      if (poke_done && done) begin
        start = 1'b1; ch_mask = 8'hFF;
      end
    end
    start = 1'b0;
    repeat (3) @(negedge ACLK);

    checks++;
    if (busy_fall < 0) begin
      errors++; $display("FAIL scan_timeout: busy never fell, budget %0d cycles", budget);
    end

    checks++;
    if (samps.size() !== n) begin
      errors++; $display("FAIL sample_count: got %0d expected %0d", samps.size(), n);
    end
    for (int j = 0; j < n && j < samps.size(); j++) begin
      c = exp_ch[j];
      checks++;
      if (samps[j].t !== s + 33 * h + 34 * h * j) begin
        errors++; $display("FAIL sample_time[%0d]: got %0d expected %0d", j, samps[j].t - s, 33 * h + 34 * h * j);
      end
      checks++;
      if (samps[j].d !== resp_word[c][11:0]) begin
        errors++; $display("FAIL sample_data[%0d]: got %h expected %h", j, samps[j].d, resp_word[c][11:0]);
      end
      checks++;
      if (samps[j].ch !== 3'(c)) begin
        errors++; $display("FAIL sample_ch[%0d]: got %0d expected %0d", j, samps[j].ch, c);
      end
      checks++;
      if (samps[j].dn !== (j == n - 1)) begin
        errors++; $display("FAIL done_with_sample[%0d]: got %b expected %b", j, samps[j].dn, (j == n - 1));
      end
    end

    checks++;
    if (frames.size() !== n) begin
      errors++; $display("FAIL frame_count: got %0d expected %0d", frames.size(), n);
    end
    for (int j = 0; j < n && j < frames.size(); j++) begin
      c  = exp_ch[j];
      ew = {2'b00, 3'(c), 11'b0};
      checks++;
      if (frames[j].fall !== s + 34 * h * j) begin
        errors++; $display("FAIL cs_fall[%0d]: got %0d expected %0d", j, frames[j].fall - s, 34 * h * j);
      end
      checks++;
      if (frames[j].rise !== frames[j].fall + 33 * h) begin
        errors++; $display("FAIL cs_low_len[%0d]: got %0d expected %0d", j, frames[j].rise - frames[j].fall, 33 * h);
      end
      checks++;
      if (frames[j].first_rise !== frames[j].fall + h) begin
        errors++; $display("FAIL first_sclk_rise[%0d]: got %0d expected %0d", j, frames[j].first_rise - frames[j].fall, h);
      end
      checks++;
      if (frames[j].last_rise !== frames[j].fall + 31 * h) begin
        errors++; $display("FAIL last_sclk_rise[%0d]: got %0d expected %0d", j, frames[j].last_rise - frames[j].fall, 31 * h);
      end
      checks++;
      if (frames[j].rises !== 16) begin
        errors++; $display("FAIL sclk_rises[%0d]: got %0d expected 16", j, frames[j].rises);
      end
      checks++;
      if (frames[j].mosi_w !== ew) begin
        errors++; $display("FAIL mosi_word[%0d]: got %h expected %h", j, frames[j].mosi_w, ew);
      end
    end

    checks++;
    if (done_cycs.size() !== 1) begin
      errors++; $display("FAIL done_count: got %0d expected 1", done_cycs.size());
    end
    if (done_cycs.size() > 0) begin
      checks++;
      if (done_cycs[0] !== t_done) begin
        errors++; $display("FAIL done_time: got %0d expected %0d", done_cycs[0] - s, t_done - s);
      end
    end
    checks++;
    if (busy_fall !== t_done + 1) begin
      errors++; $display("FAIL busy_fall_time: got %0d expected %0d", busy_fall - s, t_done + 1 - s);
    end
    checks++;
    if (rises_total - rises0 !== 16 * n) begin
      errors++; $display("FAIL total_sclk_rises: got %0d expected %0d", rises_total - rises0, 16 * n);
    end
    checks++;
    if (busy !== 1'b0 || cs_n !== 1'b1 || sclk !== 1'b0) begin
      errors++; $display("FAIL idle_after_scan: got busy=%b cs_n=%b sclk=%b expected 0 1 0", busy, cs_n, sclk);
    end
    if (n > 0) begin
      c = exp_ch[n-1];
      checks++;
      if (sample_data !== resp_word[c][11:0] || sample_ch !== 3'(c)) begin
        errors++; $display("FAIL sample_hold: got %h/%0d expected %h/%0d", sample_data, sample_ch, resp_word[c][11:0], c);
      end
    end
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    repeat (3) @(negedge ACLK);
    checks++;
    if (sclk !== 1'b0 || cs_n !== 1'b1 || mosi !== 1'b0) begin
      errors++; $display("FAIL reset_spi: got sclk=%b cs_n=%b mosi=%b expected 0 1 0", sclk, cs_n, mosi);
    end
    checks++;
    if (busy !== 1'b0 || sample_valid !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got busy=%b valid=%b done=%b expected 0 0 0", busy, sample_valid, done);
    end
    checks++;
    if (sample_data !== 12'h000 || sample_ch !== 3'd0) begin
      errors++; $display("FAIL reset_sample: got %h/%0d expected 000/0", sample_data, sample_ch);
    end
    ARESET = 1'b0;
    repeat (2) @(negedge ACLK);
  endtask

  task automatic test_single();
    resp_word[3] = 16'hFABC;
    scan_and_verify(8'h08, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic test_multi();
    for (int i = 0; i < 8; i++) resp_word[i] = 16'h0100 + 16'(i);
    // Also raises start in the done cycle, which must be ignored.
    scan_and_verify(8'hA5, 8'd0, 1'b0, 1'b1);
  endtask

  task automatic test_divider();
    resp_word[0] = 16'($urandom);
    scan_and_verify(8'h01, 8'd3, 1'b0, 1'b0);
  endtask

  task automatic test_empty();
    scan_and_verify(8'h00, 8'd0, 1'b0, 1'b1);
  endtask

  task automatic test_busy();
    resp_word[0] = 16'($urandom);
    resp_word[1] = 16'($urandom);
    scan_and_verify(8'h03, 8'd0, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    int s;
    resp_q = {};
    pulse_start(8'hFF, 8'd1, s);
    repeat (12) @(negedge ACLK);
    checks++;
    if (cs_n !== 1'b0) begin
      errors++; $display("FAIL mid_frame_before_reset: got cs_n=%b expected 0", cs_n);
    end
    @(posedge ACLK);
    #2;
    ARESET = 1'b1;
    #1;
    checks++;
    if (cs_n !== 1'b1 || sclk !== 1'b0 || mosi !== 1'b0) begin
      errors++; $display("FAIL async_reset_spi: got cs_n=%b sclk=%b mosi=%b expected 1 0 0", cs_n, sclk, mosi);
    end
    checks++;
    if (busy !== 1'b0 || sample_valid !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL async_reset_flags: got busy=%b valid=%b done=%b expected 0 0 0", busy, sample_valid, done);
    end
    @(negedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b0;
    repeat (2) @(negedge ACLK);
    for (int i = 0; i < 8; i++) resp_word[i] = 16'($urandom);
    scan_and_verify(8'($urandom_range(1, 255)), 8'd0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 8; i++) resp_word[i] = 16'($urandom);
      scan_and_verify(8'($urandom_range(0, 255)), 8'($urandom_range(0, 3)), 1'b0, k[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_divider();
    test_empty();
    test_busy();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
